board_input_debouncer: RTL and testbench

- Board-level input conditioner between raw FPGA pins (pushbuttons, slide switches) and the SoC's irq_btn_i / gpio_bi inputs.
- Per channel: synchronises the asynchronous pin, rejects bounce with a stability counter, outputs a clean level plus single-cycle rise/fall pulses.
- The button's rise pulse drives the SoC interrupt input directly.

---
 rtl/board_io_pkg.sv | 22 ++
 rtl/board_input_debouncer_debounce_ch.sv | 74 +++++++
 rtl/board_input_debouncer.sv | 78 +++++++
 tb/tb_board_input_debouncer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Shared constants, types and helpers for the board input debouncer.
// Default build counts every clock; prescaled counting is selected in the top.
package board_io_pkg;

    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int unsigned PRESCALE_DEF        = 100;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } deb_state_e;

    // Narrowest counter able to hold 0 .. n-1; never narrower than one bit.
    function automatic int unsigned cnt_width_for(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/board_input_debouncer_debounce_ch.sv
// One debounced channel: pin synchroniser, stability counter, clean level
// and registered single-cycle rise/fall pulses.
module debounce_ch
    import board_io_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_WIDTH       = cnt_width_for(DEBOUNCE_CYCLES_DEF)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_clean;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync;
    deb_state_e             w_state;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_state = (w_sync == r_clean) ? STABLE : PENDING;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_clean <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw_i};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (w_state)
                STABLE: begin
                    r_cnt <= '0;
                end
                PENDING: begin
                    // The threshold is only reachable on a counting step.
                    if (tick_i) begin
                        if (r_cnt == CNT_LAST) begin
                            r_clean <= w_sync;
                            r_cnt   <= '0;
                            r_rise  <= w_sync;
                            r_fall  <= ~w_sync;
                        end else begin
                            r_cnt <= r_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign clean_o = r_clean;
    assign rise_o  = r_rise;
    assign fall_o  = r_fall;

endmodule

// File: rtl/board_input_debouncer.sv
// Multi-channel pin debouncer. Define BOARD_DEBOUNCE_PRESCALE_EN to step the
// per-channel counters only on a shared tick every PRESCALE clocks.
module board_input_debouncer
    import board_io_pkg::*;
#(
    parameter int unsigned NUM_CH          = 17,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_WIDTH       = cnt_width_for(DEBOUNCE_CYCLES_DEF),
    parameter int unsigned PRESCALE        = PRESCALE_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] raw_i,
    output logic [NUM_CH-1:0] clean_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic              any_change_o
);

    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("board_input_debouncer: NUM_CH must be at least 1");
    end
    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync
        $error("board_input_debouncer: SYNC_STAGES must be within 2..4");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $error("board_input_debouncer: DEBOUNCE_CYCLES must be at least 1");
    end
    if ((CNT_WIDTH < 1) || (64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_WIDTH))) begin : g_bad_width
        $error("board_input_debouncer: DEBOUNCE_CYCLES exceeds 2**CNT_WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("board_input_debouncer: PRESCALE must be at least 1");
    end

    logic w_tick;

`ifdef BOARD_DEBOUNCE_PRESCALE_EN
    localparam int unsigned            PRE_W    = cnt_width_for(PRESCALE);
    localparam logic [PRE_W-1:0]       PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] r_pre;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pre <= '0;
        end else if (r_pre == PRE_LAST) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    assign w_tick = (r_pre == PRE_LAST);
`else
    assign w_tick = 1'b1;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH)
        ) u_ch (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .tick_i  (w_tick),
            .raw_i   (raw_i[g]),
            .clean_o (clean_o[g]),
            .rise_o  (rise_o[g]),
            .fall_o  (fall_o[g])
        );
    end

    assign any_change_o = |(rise_o | fall_o);

endmodule

// File: tb/tb_board_input_debouncer.sv
// Scoreboard bench: stimulus queues expected pulse events, a negedge monitor
// pops them whenever the DUT pulses and tracks the expected clean level.
module tb_board_input_debouncer;

    localparam int unsigned NCH = 4;
    localparam int unsigned LAT = 10;  // sync stages + debounce cycles

    typedef struct packed {
        int unsigned    cyc;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
        logic [NCH-1:0] clean;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [NCH-1:0] raw_i;
    logic [NCH-1:0] clean_o;
    logic [NCH-1:0] rise_o;
    logic [NCH-1:0] fall_o;
    logic           any_change_o;

    ev_t            q[$];
    int unsigned    cyc = 0;
    logic           rst_q = 1'b1;
    logic           done = 1'b0;
    logic [NCH-1:0] exp_clean = '0;
    int unsigned    n_checks = 0;
    int unsigned    n_fail = 0;

    board_input_debouncer #(
        .NUM_CH          (NCH),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .CNT_WIDTH       (3),
        .PRESCALE        (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .raw_i        (raw_i),
        .clean_o      (clean_o),
        .rise_o       (rise_o),
        .fall_o       (fall_o),
        .any_change_o (any_change_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        rst_q = rst_i;
    end

    always @(negedge clk) begin
        ev_t e;
        if (done) begin
            n_checks++;
            if (q.size() != 0) begin
                n_fail++;
                $display("FAIL leftover_events actual=%0d required=0", q.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
            $finish;
        end else begin
            if (rst_q) begin
                exp_clean = '0;
                n_checks++;
                if ({rise_o, fall_o, any_change_o} !== '0) begin
                    n_fail++;
                    $display("FAIL reset_pulses cyc=%0d actual=%b/%b/%b required=0",
                             cyc, rise_o, fall_o, any_change_o);
                end
            end else if (any_change_o || (|rise_o) || (|fall_o)) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse cyc=%0d rise=%b fall=%b any=%b",
                             cyc, rise_o, fall_o, any_change_o);
                end else begin
                    e = q.pop_front();
                    n_checks += 4;
                    if (cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL event_cycle actual=%0d required=%0d", cyc, e.cyc);
                    end
                    if (rise_o !== e.rise) begin
                        n_fail++;
                        $display("FAIL rise_o cyc=%0d actual=%b required=%b", cyc, rise_o, e.rise);
                    end
                    if (fall_o !== e.fall) begin
                        n_fail++;
                        $display("FAIL fall_o cyc=%0d actual=%b required=%b", cyc, fall_o, e.fall);
                    end
                    if (any_change_o !== 1'b1) begin
                        n_fail++;
                        $display("FAIL any_change_o cyc=%0d actual=%b required=1", cyc, any_change_o);
                    end
                    exp_clean = e.clean;
                end
            end
            n_checks++;
            if (clean_o !== exp_clean) begin
                n_fail++;
                $display("FAIL clean_level cyc=%0d actual=%b required=%b", cyc, clean_o, exp_clean);
            end
        end
    end

    task automatic wait_edges(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [NCH-1:0] r, input logic [NCH-1:0] f,
                             input logic [NCH-1:0] c);
        ev_t e;
        e.cyc   = cyc + LAT;
        e.rise  = r;
        e.fall  = f;
        e.clean = c;
        q.push_back(e);
    endtask

    initial begin
        rst_i = 1'b1;
        raw_i = 4'hF;
        wait_edges(3);

        // Release with all pins high: everything rises together.
        rst_i = 1'b0;
        expect_ev(4'hF, 4'h0, 4'hF);
        wait_edges(20);

        raw_i = 4'h0;
        expect_ev(4'h0, 4'hF, 4'h0);
        wait_edges(20);

        // Bounce on channel 0: stable runs of 3 never qualify; last toggle leaves it high.
        for (int k = 0; k < 11; k++) begin
            raw_i[0] = ~raw_i[0];
            if (k == 10) expect_ev(4'b0001, 4'b0000, 4'b0001);
            wait_edges(3);
        end
        wait_edges(20);

        raw_i[1] = 1'b1;
        expect_ev(4'b0010, 4'b0000, 4'b0011);
        wait_edges(20);

        // Simultaneous fall on ch1 and rise on ch2.
        raw_i = 4'b0101;
        expect_ev(4'b0100, 4'b0010, 4'b0101);
        wait_edges(20);

        // Reset in the middle of a ch3 settle discards the partial count.
        raw_i[3] = 1'b1;
        wait_edges(5);
        rst_i = 1'b1;
        wait_edges(3);
        rst_i = 1'b0;
        expect_ev(4'b1101, 4'b0000, 4'b1101);
        wait_edges(20);

        done = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
